// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage integer divider.
// Holds the FSM encoding, the default datapath width and the DIV/DIVU select codes.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_FIN  = 2'b10
    } div_state_e;

    // MIPS SPECIAL funct codes decoded by the execute control into is_signed.
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU = 6'b011011;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference when no borrow occurs.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             no_borrow;

    always_comb begin
        shifted   = {rem_in, bit_in};
        no_borrow = (shifted >= {2'b00, divisor});
        diff      = shifted - {2'b00, divisor};
        // The partial remainder never reaches 2*divisor, so WIDTH+1 bits always suffice.
        rem_out   = no_borrow ? (WIDTH+1)'(diff) : (WIDTH+1)'(shifted);
        q_bit     = no_borrow;
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// start/busy/done handshake, synchronous cancel and sign fix-up on the final step.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             cancel,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(ITER) + 1;

    div_state_e       state, state_next;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic             sign_q, sign_r, dbz_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] dividend_abs, divisor_abs;
    logic             accept, last;

    // quo_q doubles as the dividend shift register: its MSB feeds the next step.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .divisor (dvsr_q),
        .bit_in  (quo_q[WIDTH-1]),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        quo_step     = {quo_q[WIDTH-2:0], step_q};
        dividend_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        divisor_abs  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
        accept       = (state == DIV_IDLE) && start && !cancel;
        last         = (cnt_q == CW'(ITER - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: if (accept) state_next = DIV_CALC;
            DIV_CALC: begin
                if (cancel)    state_next = DIV_IDLE;
                else if (last) state_next = DIV_FIN;
            end
            DIV_FIN:  state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
        busy = (state != DIV_IDLE);
        done = (state == DIV_FIN) && !cancel;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= DIV_IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            dbz_q     <= 1'b0;
            cnt_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            rem_q  <= '0;
            quo_q  <= dividend_abs;
            dvsr_q <= divisor_abs;
            sign_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sign_r <= is_signed & dividend[WIDTH-1];
            dbz_q  <= (divisor == '0);
            cnt_q  <= '0;
        end else if (state == DIV_CALC && !cancel) begin
            rem_q <= step_rem;
            quo_q <= quo_step;
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
                // With a zero divisor every step succeeds, so rem ends as |dividend|
                // and the sign fix-up restores the original dividend on its own.
                quotient  <= dbz_q ? '1 : (sign_q ? -quo_step : quo_step);
                remainder <= sign_r ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];
            end
        end
    end

endmodule
